// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronised and glitch-filtered clock, 11-bit frame decode.
// Define PS2_RX_FIFO_EN for a 4-entry output FIFO; otherwise a single holding register is used.
`timescale 1ns/1ps
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic       coe_kc,
  input  logic       coe_kd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned FiltW = 4;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             kc_s1_q, kc_s2_q, kd_s1_q, kd_s2_q;
  logic             kc_filt_q, kc_filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;
  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             timeout;
  logic             deliver, pop, push, full;
  logic             perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      kc_s1_q <= 1'b1;
      kc_s2_q <= 1'b1;
      kd_s1_q <= 1'b1;
      kd_s2_q <= 1'b1;
    end else begin
      kc_s1_q <= coe_kc;
      kc_s2_q <= kc_s1_q;
      kd_s1_q <= coe_kd;
      kd_s2_q <= kd_s1_q;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_cnt_d = '0;
    kc_filt_d  = kc_filt_q;
    if (kc_s2_q != kc_filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        kc_filt_d = kc_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall    = kc_filt_q & ~kc_filt_d;
  assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    deliver   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (state_q != StIdle && !fall) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
    if (timeout) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      ferr_d    = 1'b1;
    end else if (fall) begin
      case (state_q)
        StIdle: begin
          if (!kd_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {kd_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = kd_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          if (!kd_s2_q) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      kc_filt_q  <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      kc_filt_q  <= kc_filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // A pop in the same cycle frees a slot, so a simultaneous delivery is not an overrun.
  assign pop   = out_valid & out_ready;
  assign push  = deliver & (~full | pop);
  assign ovr_d = deliver & full & ~pop;

`ifdef PS2_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;

  assign full      = (cnt_q == 3'd4);
  assign out_valid = (cnt_q != 3'd0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 3'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  assign full      = valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (push) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised scoreboard bench for ps2_frame_rx; expected bytes and error pulses come from a
// frame-level model (parity via bit counting, storage as a bounded queue).
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 400;
  localparam int          H  = 12;
`ifdef PS2_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, kc, kd, ready;
  logic [7:0] out_data;
  logic       out_valid, parity_err, frame_err, overrun;

  int checks = 0, errors = 0;
  int par_seen = 0, frm_seen = 0, ovr_seen = 0;
  int par_exp = 0, frm_exp = 0, ovr_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_data;
  logic       hold_v = 1'b0;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .csi_clk   (clk),
    .csi_reset (rst),
    .coe_kc    (kc),
    .coe_kd    (kd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and counts error pulses.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (parity_err) par_seen++;
      if (frame_err)  frm_seen++;
      if (overrun)    ovr_seen++;
      if (hold_v) check("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, hold_data});
      if (out_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte: got 0x%0h, expected no byte at %0t", out_data, $time);
        end else begin
          check("byte", out_data, exp_q.pop_front());
        end
      end
      hold_v    = out_valid && !ready;
      hold_data = out_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    kd = b;
    tick(H);
    kc = 1'b0;
    tick(H);
    kc = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    logic p;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    p = p ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    if (!stop)                    frm_exp++;
    else if (bad_par)             par_exp++;
    else if (exp_q.size() < CAP)  exp_q.push_back(d);
    else                          ovr_exp++;
    ps2_bit(stop);
    kd = 1'b1;
    tick(H);
  endtask

  task automatic check_counts(input string tag);
    tick(20);
    check({tag, "_parity_err"}, par_seen, par_exp);
    check({tag, "_frame_err"},  frm_seen, frm_exp);
    check({tag, "_overrun"},    ovr_seen, ovr_exp);
  endtask

  initial begin
    logic [7:0] d;
    int kind;
    rst   = 1'b1;
    kc    = 1'b1;
    kd    = 1'b1;
    ready = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_pulses", {29'd0, parity_err, frame_err, overrun}, 0);

    send_frame(8'h1C, 0, 1);
    check_counts("single");

    send_frame(8'hE0, 0, 1);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1C, 0, 1);
    check_counts("b2b");

    send_frame(8'h1C, 1, 1);
    check_counts("bad_parity");
    check("bad_parity_valid", out_valid, 0);
    send_frame(8'h1C, 0, 0);
    check_counts("bad_stop");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    kd = 1'b1;
    frm_exp++;
    tick(TO + 50);
    check_counts("timeout");
    send_frame(8'h29, 0, 1);
    check_counts("after_timeout");

    ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1);
    check_counts("overrun");
    check("full_valid", out_valid, 1);
    check("full_head", out_data, 8'h01);
    ready = 1'b1;
    tick(20);
    check("drained", exp_q.size(), 0);

    // Short low pulse with data low: a real strobe here would misalign the next frame.
    kd = 1'b0;
    kc = 1'b0;
    tick(FL - 2);
    kc = 1'b1;
    kd = 1'b1;
    tick(H);
    send_frame(8'h33, 0, 1);
    check_counts("glitch");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    kd  = 1'b1;
    tick(5);
    check("midreset_valid", out_valid, 0);
    send_frame(8'h5A, 0, 1);
    check_counts("after_reset");

    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      send_frame(d, kind < 2, kind != 9);
    end
    check_counts("random");
    tick(20);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
